// File: rtl/rv32i_bus_fabric.sv
// Multi-cycle memory-mapped interconnect between the RV32I core bus and up to
// NUM_REGIONS slaves: base/mask decode, per-region wait states, error responses.
module rv32i_bus_fabric #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGIONS  = 2,
  parameter int OFFSET_WIDTH = 14,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h10010000, 32'h00400000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT = {4'd2, 4'd0}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              m_req,
  input  logic                              m_we,
  input  logic [ADDR_WIDTH-1:0]             m_addr,
  input  logic [DATA_WIDTH-1:0]             m_wdata,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              m_ready,
  output logic                              m_err,
  output logic [NUM_REGIONS-1:0]            s_sel,
  output logic                              s_we,
  output logic [OFFSET_WIDTH-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] s_rdata,
  output logic [7:0]                        err_count
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        region_q, region_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [OFFSET_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]   s_wdata_q, s_wdata_d;
  logic [DATA_WIDTH-1:0]   m_rdata_q, m_rdata_d;
  logic [7:0]              err_count_q, err_count_d;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [OFFSET_WIDTH-1:0] hit_off;
  logic [3:0]              hit_wait;
  logic                    map_ok;

  // Scanning from the top index down lets the lowest hitting region win.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_off  = '0;
    hit_wait = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if ((m_addr & REGION_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(k);
        hit_off  = OFFSET_WIDTH'((m_addr & ~REGION_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) >> 2);
        hit_wait = REGION_WAIT[k*4 +: 4];
      end
    end
  end

  assign map_ok = hit && (m_addr[1:0] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      region_q    <= '0;
      cnt_q       <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_rdata_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      err_q       <= err_d;
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_rdata_q   <= m_rdata_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (m_req) state_d = map_ok ? S_ACCESS : S_RESP;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture, wait countdown and read-data capture.
  always_comb begin
    we_d        = we_q;
    err_d       = err_q;
    region_d    = region_q;
    cnt_d       = cnt_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_rdata_d   = m_rdata_q;
    err_count_d = err_count_q;
    if (state_q == S_IDLE && m_req) begin
      err_d = !map_ok;
      if (map_ok) begin
        we_d      = m_we;
        region_d  = hit_idx;
        cnt_d     = hit_wait;
        s_addr_d  = hit_off;
        s_wdata_d = m_wdata;
      end else begin
        m_rdata_d = '0;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
    end
    if (state_q == S_ACCESS) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else m_rdata_d = we_q ? '0 : s_rdata[region_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGIONS; k++) begin
      s_sel[k] = (state_q == S_ACCESS) && (region_q == IDX_W'(k));
    end
    s_we    = (state_q == S_ACCESS) && (cnt_q == 4'd0) && we_q;
    m_ready = (state_q == S_RESP);
    m_err   = (state_q == S_RESP) && err_q;
  end

  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign m_rdata   = m_rdata_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_rv32i_bus_fabric.sv
// Self-checking bench for rv32i_bus_fabric: cycle-level expectation queue built
// from the decode/latency rules, directed literal checks, and random traffic.
module tb_rv32i_bus_fabric;

  localparam logic [31:0] BASE [2] = '{32'h00400000, 32'h10010000};
  localparam logic [31:0] MASK [2] = '{32'hFFFF0000, 32'hFFFF0000};
  localparam int          WAITS[2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [63:0] s_rdata = '0;
  logic [31:0] m_rdata;
  logic        m_ready, m_err, s_we;
  logic [1:0]  s_sel;
  logic [13:0] s_addr;
  logic [31:0] s_wdata;
  logic [7:0]  err_count;

  logic [63:0] ov_s_rdata = {32'hBBBBBBBB, 32'hAAAAAAAA};
  logic [31:0] ov_m_rdata, ov_s_wdata;
  logic        ov_m_ready, ov_m_err, ov_s_we;
  logic [1:0]  ov_s_sel;
  logic [13:0] ov_s_addr;
  logic [7:0]  ov_err_count;

  rv32i_bus_fabric dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .s_sel(s_sel), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .err_count(err_count)
  );

  // Both regions decode the same window; region 1 is slower so a wrong winner shows in latency.
  rv32i_bus_fabric #(
    .REGION_BASE({32'h00400000, 32'h00400000}),
    .REGION_WAIT({4'd2, 4'd0})
  ) dut_ov (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(ov_m_rdata), .m_ready(ov_m_ready), .m_err(ov_m_err), .s_sel(ov_s_sel),
    .s_we(ov_s_we), .s_addr(ov_s_addr), .s_wdata(ov_s_wdata), .s_rdata(ov_s_rdata),
    .err_count(ov_err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  // Compare process: one expected entry per busy cycle, idle expectations otherwise.
  logic [31:0] held = '0;
  int          exp_ec = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      held   = '0;
      exp_ec = 0;
      check("rst_sel", 32'(s_sel), 0);
      check("rst_we", 32'(s_we), 0);
      check("rst_ready", 32'(m_ready), 0);
      check("rst_err", 32'(m_err), 0);
      check("rst_rdata", m_rdata, 0);
      check("rst_addr", 32'(s_addr), 0);
      check("rst_wdata", s_wdata, 0);
      check("rst_errcnt", 32'(err_count), 0);
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (e.ready) begin
        if (e.err && exp_ec < 255) exp_ec++;
        held = e.rdata;
      end
      check("sel", 32'(s_sel), 32'(e.sel));
      check("we", 32'(s_we), 32'(e.we));
      check("ready", 32'(m_ready), 32'(e.ready));
      check("err", 32'(m_err), 32'(e.err));
      check("rdata", m_rdata, held);
      check("errcnt", 32'(err_count), exp_ec);
      if (e.sel != 2'b00) begin
        check("s_addr", 32'(s_addr), 32'(e.addr));
        check("s_wdata", s_wdata, e.wdata);
      end
    end else begin
      check("idle_sel", 32'(s_sel), 0);
      check("idle_we", 32'(s_we), 0);
      check("idle_ready", 32'(m_ready), 0);
      check("idle_err", 32'(m_err), 0);
      check("idle_rdata", m_rdata, held);
      check("idle_errcnt", 32'(err_count), exp_ec);
    end
  end

  task automatic to_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  // Presents one request, records the expected cycle timeline, then drives junk
  // inputs while the fabric is busy (they must be ignored).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [63:0] rd, output int c, output int lat);
    int          k;
    logic [31:0] off;
    exp_t        e;
    c       = cyc;
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    s_rdata = rd;
    k = -1;
    for (int i = 1; i >= 0; i--) if ((addr & MASK[i]) == BASE[i]) k = i;
    if (k < 0 || addr[1:0] != 2'b00) begin
      e = '{cyc: c + 1, sel: 2'b00, addr: '0, wdata: '0, we: 1'b0, ready: 1'b1, err: 1'b1, rdata: '0};
      exp_q.push_back(e);
      lat = 1;
    end else begin
      off = (addr & ~MASK[k]) >> 2;
      for (int i = 1; i <= WAITS[k] + 1; i++) begin
        e = '{cyc: c + i, sel: 2'(1 << k), addr: off[13:0], wdata: wdata,
              we: we && (i == WAITS[k] + 1), ready: 1'b0, err: 1'b0, rdata: '0};
        exp_q.push_back(e);
      end
      e = '{cyc: c + WAITS[k] + 2, sel: 2'b00, addr: '0, wdata: '0, we: 1'b0, ready: 1'b1,
            err: 1'b0, rdata: we ? 32'h0 : rd[k*32 +: 32]};
      exp_q.push_back(e);
      lat = WAITS[k] + 2;
    end
    to_cyc(c + 1);
    m_req   = 1'b1;
    m_we    = 1'($urandom);
    m_addr  = $urandom;
    m_wdata = $urandom;
  endtask

  task automatic wait_idle(input int c, input int lat);
    to_cyc(c + lat + 1);
    m_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c, l, kind;
    logic [31:0] a;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Overlapping regions: only region 0 selected, latency 2.
    issue(1'b0, 32'h00400000, 32'h0, {32'h11111111, 32'h22222222}, c, l);
    wait_neg(c + 1);
    check("ov_sel", 32'(ov_s_sel), 32'h1);
    check("ov_ready_early", 32'(ov_m_ready), 0);
    wait_neg(c + 2);
    check("ov_ready", 32'(ov_m_ready), 1);
    check("ov_rdata", ov_m_rdata, 32'hAAAAAAAA);
    wait_idle(c, l);

    // ROM read, no wait states.
    issue(1'b0, 32'h00400008, 32'h0, {32'hCAFEF00D, 32'h00500093}, c, l);
    wait_neg(c + 1);
    check("rd_sel", 32'(s_sel), 32'h1);
    check("rd_addr", 32'(s_addr), 2);
    wait_neg(c + 2);
    check("rd_ready", 32'(m_ready), 1);
    check("rd_rdata", m_rdata, 32'h00500093);
    check("rd_err", 32'(m_err), 0);
    wait_idle(c, l);

    // RAM write, two wait states.
    issue(1'b1, 32'h10010004, 32'hDEADBEEF, {$urandom, $urandom}, c, l);
    wait_neg(c + 1);
    check("wr_sel1", 32'(s_sel), 32'h2);
    check("wr_addr", 32'(s_addr), 1);
    check("wr_we1", 32'(s_we), 0);
    wait_neg(c + 2);
    check("wr_we2", 32'(s_we), 0);
    wait_neg(c + 3);
    check("wr_we3", 32'(s_we), 1);
    check("wr_wdata", s_wdata, 32'hDEADBEEF);
    wait_neg(c + 4);
    check("wr_ready", 32'(m_ready), 1);
    check("wr_sel_resp", 32'(s_sel), 0);
    check("wr_rdata", m_rdata, 0);
    wait_idle(c, l);

    // Unmapped and misaligned reads.
    issue(1'b0, 32'h20000000, 32'h0, {$urandom, $urandom}, c, l);
    wait_neg(c + 1);
    check("um_ready", 32'(m_ready), 1);
    check("um_err", 32'(m_err), 1);
    check("um_rdata", m_rdata, 0);
    check("um_errcnt", 32'(err_count), 1);
    wait_idle(c, l);
    issue(1'b0, 32'h00400002, 32'h0, {$urandom, $urandom}, c, l);
    wait_neg(c + 1);
    check("mis_err", 32'(m_err), 1);
    check("mis_sel", 32'(s_sel), 0);
    check("mis_errcnt", 32'(err_count), 2);
    wait_idle(c, l);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = 32'h00400000 | ($urandom & 32'h0000FFFF);
        1:       a = 32'h10010000 | ($urandom & 32'h0000FFFF);
        2:       a = $urandom;
        default: a = (($urandom & 1) != 0 ? 32'h10010000 : 32'h00400000) | ($urandom & 32'h0000FFFC);
      endcase
      issue(1'($urandom), a, $urandom, {$urandom, $urandom}, c, l);
      wait_idle(c, l);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Saturation of the error counter.
    for (int n = 0; n < 300; n++) begin
      issue(1'b0, 32'h20000000, 32'h0, 64'h0, c, l);
      wait_idle(c, l);
    end
    wait_neg(cyc + 1);
    check("errcnt_sat", 32'(err_count), 255);
    @(posedge clk);
    #1;

    // Reset during the second ACCESS cycle of a RAM write.
    issue(1'b1, 32'h10010000, $urandom, {$urandom, $urandom}, c, l);
    to_cyc(c + 2);
    #1;
    rst   = 1'b0;
    m_req = 1'b0;
    #1;
    check("arst_sel", 32'(s_sel), 0);
    check("arst_we", 32'(s_we), 0);
    check("arst_ready", 32'(m_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h00400000, 32'h0, {32'h0, 32'h12345678}, c, l);
    wait_neg(c + 2);
    check("post_rst_ready", 32'(m_ready), 1);
    check("post_rst_rdata", m_rdata, 32'h12345678);
    check("post_rst_errcnt", 32'(err_count), 0);
    wait_idle(c, l);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
